seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DIV, default 4: clock cycles per digit slot; legal range 2..65535.
REQ-002 Parameter BLANK, default 1: dead-time cycles at the start of each slot; legal range 0..DIV-1.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 LOAD  in  1  one-cycle strobe; DATA captured when high.
REQ-006 DATA  in  12  three BCD digits; [3:0] digit0 on D1, [7:4] digit1 on D2, [11:8] digit2 on D3.
REQ-007 LZB  in  1  leading-zero blanking enable; sampled each cycle.
REQ-008 SEL  out  2  scan index 0,1,2; same encoding a digit switcher consumes.
REQ-009 D1, D2, D3  out  1 each  digit enables, active-high, at most one high.
REQ-010 SEG  out  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-011 PENDING  out  1  high while loaded data awaits frame transfer.
REQ-012 FRAME  out  1  high in the last cycle of slot 2.

Function
REQ-013 The block SHALL hold a slot counter CNT 0..DIV-1 and a slot index SEL; CNT increments each cycle and wraps DIV-1 -> 0; SEL advances on that wrap: 0 -> 1 -> 2 -> 0, and never takes the value 3.
REQ-014 With cycle 0 as the first cycle after RST deasserts, SEL SHALL be 0 in cycles 0..DIV-1, 1 in DIV..2DIV-1, 2 in 2DIV..3DIV-1, and then repeat with period 3*DIV.
REQ-015 While CNT < BLANK, D1..D3 SHALL be 000 and SEG SHALL be 0 (anti-ghosting dead time).
REQ-016 While CNT >= BLANK, exactly the enable selected by SEL SHALL be high (SEL=0 -> D1, 1 -> D2, 2 -> D3), and SEG SHALL show the decoded display-register digit for that slot.
REQ-017 Decode SHALL be: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; nibbles A..F SHALL show 1000000 (dash).
REQ-018 With LZB=1, digit2 SHALL be blanked when it is 0; digit1 SHALL be blanked only when digit1 and digit2 are both 0; digit0 SHALL never be blanked. A blanked slot SHALL drive its enable low and SEG=0 for the whole slot. A nibble >9 SHALL never count as zero.
REQ-019 On LOAD=1, DATA SHALL be written to the shadow register and PENDING SHALL be 1 from the next cycle; a repeated LOAD before transfer SHALL overwrite the shadow register (last write wins).
REQ-020 FRAME SHALL be 1 exactly when SEL=2 and CNT=DIV-1.
REQ-021 At the edge ending a FRAME cycle with PENDING=1, the shadow register SHALL be copied to the display register and PENDING SHALL clear; new digits first appear in the next slot 0, so a frame never mixes old and new digits.
REQ-022 When LOAD=1 in a FRAME cycle, DATA SHALL be written to both the shadow and display registers, and PENDING SHALL be 0 on the next cycle.
REQ-023 D1..D3, SEG, SEL, FRAME and PENDING SHALL be functions of registered state only, with no combinational path from LOAD, DATA or LZB to any output except via the registers. LZB is the one exception: it MAY act on blanking combinationally within the current cycle.

Reset
REQ-024 While RST=1 at an edge, the next state SHALL be: CNT=0, SEL=0, shadow=0, display=0, PENDING=0.
REQ-025 During reset and in the cycle after it, the outputs SHALL be D1..D3=000, SEG=0, FRAME=0, PENDING=0.
REQ-026 A reset asserted mid-slot or mid-frame SHALL abort the scan and any pending transfer; scanning SHALL restart at slot 0 with its blank phase.

Verification (DIV=4, BLANK=1)
REQ-027 Scenario 1: RST=1 for 3 cycles, then release.
- During reset: SEL=0, D=000, SEG=0, PENDING=0, FRAME=0.
- After release: FRAME is first high at cycle 11; SEL cycles 0,1,2 every 4 cycles.
REQ-028 Scenario 2: LOAD with DATA=12'h123 at cycle 2.
- PENDING=1 in cycles 3..11.
- Cycles 13..15: D1=1, SEG=1001111.
- Cycles 17..19: D2=1, SEG=1011011.
- Cycles 21..23: D3=1, SEG=0000110.
- Cycles 12, 16 and 20: D=000.
REQ-029 Scenario 3: display holding 12'h007.
- With LZB=1: D2 and D3 stay 0 for the whole frame; D1 slot shows SEG=0000111.
- With LZB=0: D3 slot and D2 slot both show 0111111.
REQ-030 Scenario 4: DATA=12'h0A0 with LZB=1.
- D2 slot shows SEG=1000000.
- D3 slot is blanked.
- D1 slot shows 0111111.
REQ-031 Scenario 5: LOAD 12'h456 asserted in the FRAME cycle.
- PENDING stays 0.
- The next frame shows 6, 5, 4.
- A second LOAD 12'h999 in the same frame before the next FRAME cycle is displayed one frame later.
REQ-032 Scenario 6: RST pulsed for 1 cycle during slot 2 with PENDING=1.
- Next cycle: all outputs at reset values and PENDING=0.
- Following frame shows 0 in all three digits (LZB=0).

Source files
------------

// File: rtl/seg_scan_driver.sv
// Three-digit multiplexed 7-segment scanner with per-slot dead time,
// leading-zero blanking and frame-synchronous display update.
module seg_scan_driver #(
   parameter int unsigned DIV   = 4,
   parameter int unsigned BLANK = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        LOAD,
   input  logic [11:0] DATA,
   input  logic        LZB,
   output logic [1:0]  SEL,
   output logic        D1,
   output logic        D2,
   output logic        D3,
   output logic [6:0]  SEG,
   output logic        PENDING,
   output logic        FRAME
);

   typedef enum logic [1:0] {
      SLOT0 = 2'd0,
      SLOT1 = 2'd1,
      SLOT2 = 2'd2
   } slot_e;

   localparam logic [15:0] LAST = 16'(DIV - 1);
   localparam logic [15:0] BLK  = 16'(BLANK);

   logic [15:0] cnt_q, cnt_d;
   slot_e       sel_q, sel_d;
   logic [11:0] shadow_q, shadow_d;
   logic [11:0] disp_q, disp_d;
   logic        pend_q, pend_d;
   logic        rst_q;

   logic        frame_w;
   logic [3:0]  nib;
   logic        lz_blank;
   logic        dark;
   logic [2:0]  en;

   function automatic logic [6:0] dec7(input logic [3:0] n);
      logic [6:0] s;
      s = 7'b1000000;
      case (n)
         4'd0: s = 7'b0111111;
         4'd1: s = 7'b0000110;
         4'd2: s = 7'b1011011;
         4'd3: s = 7'b1001111;
         4'd4: s = 7'b1100110;
         4'd5: s = 7'b1101101;
         4'd6: s = 7'b1111101;
         4'd7: s = 7'b0000111;
         4'd8: s = 7'b1111111;
         4'd9: s = 7'b1101111;
         default: s = 7'b1000000;
      endcase
      return s;
   endfunction

   assign frame_w = (sel_q == SLOT2) && (cnt_q == LAST);

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q    <= '0;
         sel_q    <= SLOT0;
         shadow_q <= '0;
         disp_q   <= '0;
         pend_q   <= 1'b0;
         rst_q    <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         rst_q    <= 1'b0;
      end
   end

   always_comb begin
      cnt_d    = cnt_q + 16'd1;
      sel_d    = sel_q;
      shadow_d = LOAD ? DATA : shadow_q;
      disp_d   = disp_q;
      pend_d   = pend_q;
      if (cnt_q == LAST) begin
         cnt_d = '0;
         unique case (sel_q)
            SLOT0:   sel_d = SLOT1;
            SLOT1:   sel_d = SLOT2;
            default: sel_d = SLOT0;
         endcase
      end
      // Display only changes at the frame boundary so a frame never tears.
      if (frame_w) begin
         pend_d = 1'b0;
         if (LOAD) begin
            disp_d = DATA;
         end else if (pend_q) begin
            disp_d = shadow_q;
         end
      end else if (LOAD) begin
         pend_d = 1'b1;
      end
   end

   always_comb begin
      nib      = disp_q[3:0];
      lz_blank = 1'b0;
      en       = 3'b001;
      unique case (sel_q)
         SLOT1: begin
            nib      = disp_q[7:4];
            lz_blank = LZB && (disp_q[11:4] == 8'h00);
            en       = 3'b010;
         end
         SLOT2: begin
            nib      = disp_q[11:8];
            lz_blank = LZB && (disp_q[11:8] == 4'h0);
            en       = 3'b100;
         end
         default: begin
            nib      = disp_q[3:0];
            lz_blank = 1'b0;
            en       = 3'b001;
         end
      endcase
   end

   assign dark = RST || rst_q || (cnt_q < BLK) || lz_blank;

   assign {D3, D2, D1} = dark ? 3'b000 : en;
   assign SEG          = dark ? 7'd0 : dec7(nib);
   assign SEL          = RST ? 2'd0 : sel_q;
   assign FRAME        = frame_w && !RST;
   assign PENDING      = pend_q && !RST;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: slot-arithmetic reference model checked every
// cycle, plus hand-written expectation tables for the key scenarios.
module tb_seg_scan_driver;

   localparam int DIV   = 4;
   localparam int BLANK = 1;
   localparam int FR    = 3 * DIV;

   logic        CLK  = 1'b0;
   logic        RST  = 1'b1;
   logic        LOAD = 1'b0;
   logic [11:0] DATA = '0;
   logic        LZB  = 1'b0;
   logic [1:0]  SEL;
   logic        D1, D2, D3;
   logic [6:0]  SEG;
   logic        PENDING, FRAME;

   int total = 0;
   int bad   = 0;

   seg_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
      .CLK(CLK), .RST(RST), .LOAD(LOAD), .DATA(DATA), .LZB(LZB),
      .SEL(SEL), .D1(D1), .D2(D2), .D3(D3), .SEG(SEG),
      .PENDING(PENDING), .FRAME(FRAME)
   );

   always #5 CLK = ~CLK;

   // Reference state: cycles since reset plus the register contents.
   int          t;
   logic [11:0] m_sh, m_disp;
   bit          m_pend, m_after;

   typedef struct {
      int          cyc;
      logic [13:0] mask;
      logic [13:0] val;
   } hand_t;
   hand_t hq[$];
   bit    hand_en = 0;

   typedef struct {
      logic [3:0] nib;
      logic [6:0] seg;
   } dec_t;
   dec_t dtab[16];

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'd0: return 7'b0111111;
         4'd1: return 7'b0000110;
         4'd2: return 7'b1011011;
         4'd3: return 7'b1001111;
         4'd4: return 7'b1100110;
         4'd5: return 7'b1101101;
         4'd6: return 7'b1111101;
         4'd7: return 7'b0000111;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1101111;
         default: return 7'b1000000;
      endcase
   endfunction

   function automatic logic [13:0] actual();
      return {SEL, D3, D2, D1, SEG, FRAME, PENDING};
   endfunction

   function automatic logic [13:0] expect_v();
      int slot, c;
      logic [3:0] dg;
      bit blk;
      logic [2:0] d;
      logic [11:0] dd;
      if (RST) return 14'd0;
      slot = (t / DIV) % 3;
      c    = t % DIV;
      dd   = m_disp >> (4 * slot);
      dg   = dd[3:0];
      blk  = m_after || (c < BLANK)
             || (LZB && slot == 2 && m_disp[11:8] == 4'h0)
             || (LZB && slot == 1 && m_disp[11:4] == 8'h00);
      d    = blk ? 3'b000 : 3'(1 << slot);
      return {2'(slot), d, blk ? 7'd0 : seg_of(dg),
              1'(slot == 2 && c == DIV - 1), 1'(m_pend)};
   endfunction

   task automatic model_update();
      bit fr;
      if (RST) begin
         t = 0; m_sh = 0; m_disp = 0; m_pend = 0; m_after = 1;
      end else begin
         fr = ((t / DIV) % 3 == 2) && (t % DIV == DIV - 1);
         if (fr) begin
            if (LOAD) m_disp = DATA;
            else if (m_pend) m_disp = m_sh;
            m_pend = 0;
         end else if (LOAD) begin
            m_pend = 1;
         end
         if (LOAD) m_sh = DATA;
         t++;
         m_after = 0;
      end
   endtask

   task automatic cmp(input string nm, input logic [13:0] a,
                      input logic [13:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s t=%0d got=%h want=%h", nm, t, a, e);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      cmp("model", actual(), expect_v());
      if (hand_en)
         foreach (hq[i])
            if (hq[i].cyc == t)
               cmp("hand", actual() & hq[i].mask, hq[i].val);
      @(posedge CLK);
      model_update();
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic align(input int ph);
      int n;
      n = 0;
      while ((t % FR) != ph && n < 4 * FR) begin
         tick();
         n++;
      end
      if ((t % FR) != ph) cmp("align_timeout", 14'd1, 14'd0);
   endtask

   task automatic load(input logic [11:0] v);
      LOAD = 1'b1;
      DATA = v;
      tick();
      LOAD = 1'b0;
   endtask

   function automatic hand_t mk(input int c, input logic [13:0] m,
                                input logic [13:0] v);
      hand_t h;
      h.cyc = c; h.mask = m; h.val = v;
      return h;
   endfunction

   localparam logic [13:0] M_P  = 14'h0001;
   localparam logic [13:0] M_F  = 14'h0002;
   localparam logic [13:0] M_DS = 14'h0FFC;
   localparam logic [13:0] M_S  = 14'h3000;

   initial begin
      // Hand expectations for reset release + LOAD 123 at cycle 2.
      for (int c = 3; c <= 11; c++) hq.push_back(mk(c, M_P, 14'h0001));
      hq.push_back(mk(12, M_DS | M_P, 14'h0000));
      for (int c = 13; c <= 15; c++)
         hq.push_back(mk(c, M_DS, {2'b00, 3'b001, 7'b1001111, 2'b00}));
      for (int c = 17; c <= 19; c++)
         hq.push_back(mk(c, M_DS, {2'b00, 3'b010, 7'b1011011, 2'b00}));
      for (int c = 21; c <= 23; c++)
         hq.push_back(mk(c, M_DS, {2'b00, 3'b100, 7'b0000110, 2'b00}));
      hq.push_back(mk(16, M_DS, 14'h0000));
      hq.push_back(mk(20, M_DS, 14'h0000));
      hq.push_back(mk(10, M_F, 14'h0000));
      hq.push_back(mk(11, M_F, 14'h0002));
      hq.push_back(mk(0, M_S, 14'h0000));
      hq.push_back(mk(4, M_S, 14'h1000));
      hq.push_back(mk(8, M_S, 14'h2000));

      dtab[0]  = '{4'h0, 7'b0111111}; dtab[1]  = '{4'h1, 7'b0000110};
      dtab[2]  = '{4'h2, 7'b1011011}; dtab[3]  = '{4'h3, 7'b1001111};
      dtab[4]  = '{4'h4, 7'b1100110}; dtab[5]  = '{4'h5, 7'b1101101};
      dtab[6]  = '{4'h6, 7'b1111101}; dtab[7]  = '{4'h7, 7'b0000111};
      dtab[8]  = '{4'h8, 7'b1111111}; dtab[9]  = '{4'h9, 7'b1101111};
      dtab[10] = '{4'hA, 7'b1000000}; dtab[11] = '{4'hB, 7'b1000000};
      dtab[12] = '{4'hC, 7'b1000000}; dtab[13] = '{4'hD, 7'b1000000};
      dtab[14] = '{4'hE, 7'b1000000}; dtab[15] = '{4'hF, 7'b1000000};

      // Reset for 3 edges, then release.
      @(posedge CLK);
      model_update();
      #1;
      ticks(2);
      RST = 1'b0;
      hand_en = 1;
      ticks(2);
      load(12'h123);
      ticks(21);
      hand_en = 0;

      // Display 007 with and without leading-zero blanking.
      load(12'h007);
      LZB = 1'b1;
      ticks(3 * FR);
      LZB = 1'b0;
      ticks(2 * FR);

      // Non-decimal middle digit never counts as zero.
      LZB = 1'b1;
      load(12'h0A0);
      ticks(3 * FR);
      LZB = 1'b0;

      // LOAD in the FRAME cycle, then a second LOAD within the frame.
      align(FR - 1);
      load(12'h456);
      ticks(3);
      load(12'h999);
      ticks(3 * FR);

      // Reset during slot 2 with a transfer pending.
      align(2 * DIV);
      load(12'h321);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      ticks(2 * FR);

      // Decoder sweep: each nibble in all digits, check slot 0 after BLANK.
      foreach (dtab[i]) begin
         load({dtab[i].nib, dtab[i].nib, dtab[i].nib});
         align(FR - 1);
         tick();
         tick();
         @(negedge CLK);
         cmp("decode", {4'h0, D3, D2, D1, SEG},
             {4'h0, 3'b001, dtab[i].seg});
         @(posedge CLK);
         model_update();
         #1;
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         RST  = ($urandom_range(0, 249) == 0);
         LOAD = ($urandom_range(0, 5) == 0);
         DATA = 12'($urandom);
         if ($urandom_range(0, 1) == 0) DATA[11:8] = 4'h0;
         if ($urandom_range(0, 2) == 0) DATA[7:4] = 4'h0;
         if ($urandom_range(0, 15) == 0) LZB = ~LZB;
         tick();
      end
      RST = 1'b0;
      LOAD = 1'b0;
      ticks(FR);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
